// File: rtl/regfile_writeback.sv
// Y86-64 architectural state: fifteen 64-bit program registers, condition codes and
// processor status, committed from execute/memory results on each enabled clock edge.
module regfile_writeback #(
    parameter logic [3:0] RSP_ID   = 4'h4,
    parameter logic [2:0] CC_RESET = 3'b001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [2:0]  cf_new,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [2:0]  cc,
    output logic [2:0]  stat,
    output logic        halted
);

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_INS = 3'd4
    } stat_e;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [63:0] regs [0:14];
    logic [2:0]  cc_q;
    stat_e       stat_q;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        active;
    logic        commit;

    assign cc     = cc_q;
    assign stat   = stat_q;
    assign halted = (stat_q != STAT_AOK);

    // Once stopped, en and icode are ignored; only valid icodes 1..B commit state.
    assign active = en && !halted;
    assign commit = active && (icode != I_HALT) && (icode <= I_POPQ);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (icode)
            I_RRMOVQ:                         dst_e = cnd ? rB : REG_NONE;
            I_IRMOVQ, I_OPQ:                  dst_e = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:   dst_e = RSP_ID;
            default:                          dst_e = REG_NONE;
        endcase
        if (icode == I_MRMOVQ || icode == I_POPQ)
            dst_m = rA;
    end

    always_comb begin
        valA = '0;
        valB = '0;
        for (int i = 0; i < 15; i++) begin
            if (srcA == 4'(i)) valA = regs[i];
            if (srcB == 4'(i)) valB = regs[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
    // NOTE: the register file is reset explicitly because architectural reset state is all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) regs[i] <= '0;
            cc_q   <= CC_RESET;
            stat_q <= STAT_AOK;
        end else begin
            // The valM write comes last so it wins when dst_e == dst_m (popq %rsp).
            for (int i = 0; i < 15; i++) begin
                if (commit && dst_e == 4'(i)) regs[i] <= valE;
                if (commit && dst_m == 4'(i)) regs[i] <= valM;
            end
            if (commit && icode == I_OPQ)
                cc_q <= cf_new;
            if (active && icode == I_HALT)
                stat_q <= STAT_HLT;
            else if (active && icode > I_POPQ)
                stat_q <= STAT_INS;
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a driver pushes expected outputs from a
// spec-level model into a queue; a monitor pops and compares each cycle.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  icode, rA, rB, srcA, srcB;
    logic        cnd;
    logic [63:0] valE, valM, valA, valB;
    logic [2:0]  cf_new, cc, stat;
    logic        halted;

    regfile_writeback dut (
        .clk(clk), .rst_n(rst_n), .en(en), .icode(icode), .rA(rA), .rB(rB),
        .cnd(cnd), .valE(valE), .valM(valM), .cf_new(cf_new),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .cc(cc), .stat(stat), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  cc;
        logic [2:0]  stat;
        logic        h;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: architectural state as plain arrays.
    logic [63:0] m_reg [0:14];
    logic [2:0]  m_cc;
    logic [2:0]  m_stat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_read(input logic [3:0] id);
        return (id == 4'hF) ? 64'd0 : m_reg[id];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_reg[i] = '0;
        m_cc   = 3'b001;
        m_stat = 3'd1;
    endtask

    task automatic model_step(input logic e, input logic [3:0] ic, input logic [3:0] ra,
                              input logic [3:0] rb, input logic c, input logic [63:0] ve,
                              input logic [63:0] vm, input logic [2:0] cf);
        logic [3:0] we;
        logic [3:0] wm;
        we = 4'hF;
        wm = 4'hF;
        if (!e || m_stat != 3'd1) return;
        if (ic == 4'h0) begin
            m_stat = 3'd2;
        end else if (ic > 4'hB) begin
            m_stat = 3'd4;
        end else begin
            if ((ic == 4'h2 && c) || ic == 4'h3 || ic == 4'h6) we = rb;
            if (ic >= 4'h8) we = 4'h4;
            if (ic == 4'h5 || ic == 4'hB) wm = ra;
            if (we != 4'hF) m_reg[we] = ve;
            if (wm != 4'hF) m_reg[wm] = vm;
            if (ic == 4'h6) m_cc = cf;
        end
    endtask

    // One clock cycle: drive after the edge, record what the outputs must show now,
    // then advance the model to the state the next edge commits.
    task automatic do_cycle(input logic e, input logic [3:0] ic, input logic [3:0] ra,
                            input logic [3:0] rb, input logic c, input logic [63:0] ve,
                            input logic [63:0] vm, input logic [2:0] cf,
                            input logic [3:0] sa, input logic [3:0] sb);
        exp_t x;
        @(posedge clk);
        #1;
        en = e; icode = ic; rA = ra; rB = rb; cnd = c;
        valE = ve; valM = vm; cf_new = cf; srcA = sa; srcB = sb;
        x.a = m_read(sa);
        x.b = m_read(sb);
        x.cc = m_cc;
        x.stat = m_stat;
        x.h = (m_stat != 3'd1);
        exp_q.push_back(x);
        model_step(e, ic, ra, rb, c, ve, vm, cf);
    endtask

    task automatic idle(input logic [3:0] sa, input logic [3:0] sb);
        do_cycle(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, '0, '0, '0, sa, sb);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #10;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always begin
        exp_t x;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("valA", valA, x.a);
            check("valB", valB, x.b);
            check("cc", 64'(cc), 64'(x.cc));
            check("stat", 64'(stat), 64'(x.stat));
            check("halted", 64'(halted), 64'(x.h));
        end
    end

    initial begin
        logic [3:0] ic;
        int r;
        rst_n = 1'b1; en = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
        valE = '0; valM = '0; cf_new = '0; srcA = 4'hF; srcB = 4'hF;
        model_reset();
        #3 rst_n = 1'b0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sequence.
        idle(4'h0, 4'hE);
        do_cycle(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, '0, '0, 4'h2, 4'hF);
        do_cycle(1'b1, 4'h6, 4'hF, 4'h2, 1'b0, 64'h0, '0, 3'b001, 4'h2, 4'h5);
        do_cycle(1'b1, 4'h6, 4'hF, 4'h3, 1'b0, 64'h55, '0, 3'b110, 4'h2, 4'h3);
        do_cycle(1'b1, 4'h2, 4'hF, 4'h5, 1'b0, 64'h7, '0, 3'b011, 4'h5, 4'h3);
        do_cycle(1'b1, 4'h2, 4'hF, 4'h5, 1'b1, 64'h7, '0, 3'b011, 4'h5, 4'h3);
        do_cycle(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hABC, '0, 4'h5, 4'h4);
        do_cycle(1'b1, 4'hA, 4'hF, 4'hF, 1'b0, 64'hF8, 64'h1, '0, 4'h4, 4'h5);
        do_cycle(1'b0, 4'h6, 4'hF, 4'h4, 1'b0, 64'hDEAD, '0, 3'b111, 4'h4, 4'h5);
        do_cycle(1'b1, 4'h0, 4'hF, 4'hF, 1'b0, '0, '0, '0, 4'h4, 4'h5);
        do_cycle(1'b1, 4'h3, 4'hF, 4'h4, 1'b0, 64'h999, '0, '0, 4'h4, 4'h5);
        do_cycle(1'b1, 4'hC, 4'hF, 4'h4, 1'b0, 64'h999, '0, '0, 4'h4, 4'h5);
        idle(4'h4, 4'h2);

        apply_reset();
        do_cycle(1'b1, 4'hC, 4'hF, 4'h1, 1'b0, 64'h77, '0, '0, 4'h1, 4'h4);
        do_cycle(1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'h77, '0, '0, 4'h1, 4'h4);
        idle(4'h1, 4'h4);

        // Randomized epochs, each ended by a mid-cycle asynchronous reset.
        for (int ep = 0; ep < 4; ep++) begin
            apply_reset();
            for (int n = 0; n < 150; n++) begin
                r = $urandom_range(0, 99);
                if (r < 2) begin
                    r = $urandom_range(0, 4);
                    ic = (r == 0) ? 4'h0 : 4'(11 + r);
                end else begin
                    ic = 4'($urandom_range(1, 11));
                end
                do_cycle(($urandom_range(0, 9) < 8), ic, 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                         {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            @(negedge clk);
            #2;
            srcA = 4'h4;
            srcB = 4'($urandom_range(0, 14));
            rst_n = 1'b0;
            #1;
            check("async_valA", valA, 64'd0);
            check("async_valB", valB, 64'd0);
            check("async_cc", 64'(cc), 64'(3'b001));
            check("async_stat", 64'(stat), 64'(3'd1));
            check("async_halted", 64'(halted), 64'd0);
            rst_n = 1'b1;
            model_reset();
        end

        @(negedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
